// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit index counter width; never below 1 so the counter always exists.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder used as the serial datapath slice.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic x,
    output logic s_c,
    output logic c_c
);

    always_comb begin
        s_c = a ^ b ^ x;
        c_c = (a & b) | (a & x) | (b & x);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: operands are shifted LSB-first through a single
// full adder, the carry is held in a flop, and the result returns on a handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             fa_s_c, fa_c_c;
    logic             last_c;

    serial_add_ctrl_fa u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .x   (carry_q),
        .s_c (fa_s_c),
        .c_c (fa_c_c)
    );

    assign last_c = (count_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_comb begin
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        count_d     = count_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                end
            end
            RUN: begin
                sum_d   = {fa_s_c, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c_c;
                if (last_c) begin
                    cout_d = fa_c_c;
                    ovf_d  = carry_q ^ fa_c_c;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, sub_in, cin_in;
    logic [63:0] a_in, b_in;

    logic        in_ready8, out_valid8, cout8, ovf8, busy8;
    logic [7:0]  sum8;
    logic        in_ready13, out_valid13, cout13, ovf13, busy13;
    logic [12:0] sum13;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] r_sum8, r_sum13;
    logic        r_cout8, r_ovf8, r_cout13, r_ovf13;
    int          r_lat8, r_lat13;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a_in[7:0]), .b(b_in[7:0]), .sub(sub_in), .cin(cin_in),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready13),
        .a(a_in[12:0]), .b(b_in[12:0]), .sub(sub_in), .cin(cin_in),
        .out_valid(out_valid13), .out_ready(out_ready), .sum(sum13),
        .cout(cout13), .ovf(ovf13), .busy(busy13)
    );

    // Arithmetic reference: sum/carry from wide addition, overflow from carry into MSB.
    function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input logic cin,
                                      output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] mask, lmask, aa, bb, full, low;
        logic        c0;
        mask  = (65'd1 << w) - 65'd1;
        lmask = (65'd1 << (w - 1)) - 65'd1;
        aa    = {1'b0, a} & mask;
        bb    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        c0    = sub ? 1'b1 : cin;
        full  = aa + bb + 65'(c0);
        low   = (aa & lmask) + (bb & lmask) + 65'(c0);
        s     = full[63:0] & mask[63:0];
        co    = full[w];
        ov    = low[w-1] ^ full[w];
    endfunction

    task automatic accept_op(input logic [63:0] a, input logic [63:0] b,
                             input logic sub, input logic cin);
        int guard = 0;
        while (!(in_ready8 && in_ready13) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_tests++;
        if (!(in_ready8 && in_ready13)) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready8=%0b in_ready13=%0b, required 1 1", in_ready8, in_ready13);
        end
        a_in = a; b_in = b; sub_in = sub; cin_in = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) until both results are valid; latency counted in edges after accept.
    task automatic wait_done();
        logic g8 = 1'b0, g13 = 1'b0;
        r_lat8 = 0; r_lat13 = 0;
        for (int i = 1; i <= 100 && !(g8 && g13); i++) begin
            @(posedge clk); #1;
            if (!g8 && out_valid8) begin
                g8 = 1'b1; r_lat8 = i; r_sum8 = 64'(sum8); r_cout8 = cout8; r_ovf8 = ovf8;
            end
            if (!g13 && out_valid13) begin
                g13 = 1'b1; r_lat13 = i; r_sum13 = 64'(sum13); r_cout13 = cout13; r_ovf13 = ovf13;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready8, out_valid8, busy8, cout8, ovf8, sum8} !== 13'b1_0000_0000_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b vld=%0b busy=%0b cout=%0b ovf=%0b sum=%h, required 1 0 0 0 0 00",
                     in_ready8, out_valid8, busy8, cout8, ovf8, sum8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready8, out_valid8, busy8} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle: rdy=%0b vld=%0b busy=%0b, required 1 0 0", in_ready8, out_valid8, busy8);
        end
    endtask

    task automatic test_add();
        accept_op(64'h5A, 64'h3C, 1'b0, 1'b0);
        n_tests++;
        if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy: busy=%0b in_ready=%0b, required 1 0", busy8, in_ready8);
        end
        wait_done();
        n_tests++;
        if (r_lat8 != 8) begin
            n_fail++;
            $display("FAIL add_latency: %0d edges, required 8", r_lat8);
        end
        n_tests++;
        if ({r_sum8[7:0], r_cout8, r_ovf8} !== {8'h96, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_5a_3c: sum=%h cout=%0b ovf=%0b, required 96 0 1", r_sum8[7:0], r_cout8, r_ovf8);
        end
        n_tests++;
        if (r_lat13 != 13) begin
            n_fail++;
            $display("FAIL add_latency13: %0d edges, required 13", r_lat13);
        end
        release_result();
        n_tests++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL add_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_carry();
        accept_op(64'hFF, 64'h01, 1'b0, 1'b0);
        wait_done();
        n_tests++;
        if ({r_sum8[7:0], r_cout8, r_ovf8} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_ff_01: sum=%h cout=%0b ovf=%0b, required 00 1 0", r_sum8[7:0], r_cout8, r_ovf8);
        end
        release_result();
        accept_op(64'h7F, 64'h00, 1'b0, 1'b1);
        wait_done();
        n_tests++;
        if ({r_sum8[7:0], r_cout8, r_ovf8} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL carry_7f_cin: sum=%h cout=%0b ovf=%0b, required 80 0 1", r_sum8[7:0], r_cout8, r_ovf8);
        end
        release_result();
    endtask

    task automatic test_sub();
        accept_op(64'h10, 64'h20, 1'b1, 1'b0);
        wait_done();
        n_tests++;
        if ({r_sum8[7:0], r_cout8, r_ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_10_20: sum=%h cout=%0b ovf=%0b, required f0 0 0", r_sum8[7:0], r_cout8, r_ovf8);
        end
        release_result();
        // cin must be ignored when subtracting
        accept_op(64'h20, 64'h10, 1'b1, 1'b1);
        wait_done();
        n_tests++;
        if ({r_sum8[7:0], r_cout8, r_ovf8} !== {8'h10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_20_10: sum=%h cout=%0b ovf=%0b, required 10 1 0", r_sum8[7:0], r_cout8, r_ovf8);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        accept_op(64'h21, 64'h12, 1'b0, 1'b0);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            a_in = 64'h01; b_in = 64'h01; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            if (out_valid8 !== 1'b1 || sum8 !== 8'h33 || in_ready8 !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles (last vld=%0b sum=%h rdy=%0b), required 0 (1 33 0)",
                     bad, out_valid8, sum8, in_ready8);
        end
        release_result();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_no_accept: busy=%0b out_valid=%0b, required 0 0", busy8, out_valid8);
        end
    endtask

    task automatic test_reset_mid();
        accept_op(64'hAA, 64'h55, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_running: busy=%0b, required 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy8, out_valid8, in_ready8, sum8} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_clear: busy=%0b vld=%0b rdy=%0b sum=%h, required 0 0 1 00",
                     busy8, out_valid8, in_ready8, sum8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        accept_op(64'h03, 64'h04, 1'b0, 1'b0);
        wait_done();
        n_tests++;
        if (r_sum8[7:0] !== 8'h07) begin
            n_fail++;
            $display("FAIL midreset_after: sum=%h, required 07", r_sum8[7:0]);
        end
        release_result();
    endtask

    // With both handshakes held high the controller spends WIDTH+1 cycles busy,
    // so accepting edges land WIDTH+2 edges apart.
    task automatic test_back_to_back();
        int hs_edges[$];
        logic hs;
        a_in = 64'h11; b_in = 64'h22; sub_in = 1'b0; cin_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            hs = in_valid && in_ready8;
            @(posedge clk); #1;
            if (hs) hs_edges.push_back(e);
        end
        in_valid = 1'b0;
        n_tests++;
        if (hs_edges.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d accepts in 25 edges, required 3", hs_edges.size());
        end
        n_tests++;
        if (hs_edges.size() < 2 || (hs_edges[1] - hs_edges[0]) != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d accepts, gap %0d, required gap 10", hs_edges.size(),
                     (hs_edges.size() >= 2) ? hs_edges[1] - hs_edges[0] : -1);
        end
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] a, b, e8, e13;
        logic        sub, cin, c8, v8, c13, v13;
        for (int i = 0; i < 1000; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            ref_model(8, a, b, sub, cin, e8, c8, v8);
            ref_model(13, a, b, sub, cin, e13, c13, v13);
            accept_op(a, b, sub, cin);
            wait_done();
            n_tests++;
            if ({r_sum8[7:0], r_cout8, r_ovf8} !== {e8[7:0], c8, v8} || r_lat8 != 8) begin
                n_fail++;
                $display("FAIL rand8[%0d]: sum=%h cout=%0b ovf=%0b lat=%0d, required %h %0b %0b 8",
                         i, r_sum8[7:0], r_cout8, r_ovf8, r_lat8, e8[7:0], c8, v8);
            end
            n_tests++;
            if ({r_sum13[12:0], r_cout13, r_ovf13} !== {e13[12:0], c13, v13} || r_lat13 != 13) begin
                n_fail++;
                $display("FAIL rand13[%0d]: sum=%h cout=%0b ovf=%0b lat=%0d, required %h %0b %0b 13",
                         i, r_sum13[12:0], r_cout13, r_ovf13, r_lat13, e13[12:0], c13, v13);
            end
            release_result();
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; sub_in = 1'b0; cin_in = 1'b0;
        a_in = '0; b_in = '0;
        r_sum8 = '0; r_sum13 = '0; r_cout8 = 1'b0; r_ovf8 = 1'b0; r_cout13 = 1'b0; r_ovf13 = 1'b0;
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
